// File: rtl/accum_result_collector_pkg.sv
// accum_result_collector_pkg: shared types and default sizing for the result collector
package accum_result_collector_pkg;

    localparam int DEF_MAX_SIZE_BITS = 9;
    localparam int DEF_FIFO_DEPTH    = 4;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] i;
    } complex_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/complex_result_fifo.sv
// complex_result_fifo: show-ahead FIFO of complex results with sticky drop flag
module complex_result_fifo
    import accum_result_collector_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     i_push,
    input  complex_t i_data,
    input  logic     i_pop,
    output complex_t o_data,
    output logic     o_valid,
    output logic     o_overflow
);

    localparam int AW = $clog2(DEPTH);

    complex_t       r_mem [DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [AW:0]    r_count;
    logic           r_overflow;
    logic           w_pop;
    logic           w_full;
    logic           w_push;

    // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
    assign o_valid    = r_count != '0;
    assign w_pop      = i_pop && o_valid;
    assign w_full     = r_count == (AW+1)'(DEPTH);
    assign w_push     = i_push && (!w_full || w_pop);
    assign o_data     = o_valid ? r_mem[r_rd] : '0;
    assign o_overflow = r_overflow;

    // Storage write; contents are masked by o_valid so they need no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    // Pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (i_push && !w_push) r_overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/accum_result_collector.sv
// accum_result_collector: captures the last sample of each accumulator frame into a result FIFO
module accum_result_collector
    import accum_result_collector_pkg::*;
#(
    parameter int MAX_SIZE_BITS = DEF_MAX_SIZE_BITS,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  complex_t                 in,
    input  logic                     next,
    input  logic                     config_valid,
    input  logic [MAX_SIZE_BITS-1:0] config_length,
    output logic                     busy,
    output logic                     cfg_err,
    output complex_t                 out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [MAX_SIZE_BITS-1:0] r_idx;
    logic [MAX_SIZE_BITS:0]   r_len;
    logic                     r_cfg_err;
    logic [MAX_SIZE_BITS:0]   w_len_dec;
    logic                     w_cfg_bad;
    logic                     w_cfg_ok;
    logic                     w_at_last;
    logic                     w_push;

    // An encoded length of zero stands for the largest frame, 2**MAX_SIZE_BITS.
    assign w_len_dec = (config_length == '0) ? {1'b1, {MAX_SIZE_BITS{1'b0}}} : {1'b0, config_length};
    assign w_at_last = r_idx == MAX_SIZE_BITS'(r_len - 1'b1);
    assign busy      = r_state != S_IDLE;
    assign cfg_err   = r_cfg_err;

    // Next-state and control decode; config is only looked at in IDLE, next only in WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_cfg_bad   = 1'b0;
        w_cfg_ok    = 1'b0;
        w_push      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cfg_bad = config_valid && (config_length == MAX_SIZE_BITS'(1) || config_length == MAX_SIZE_BITS'(2));
                w_cfg_ok  = config_valid && !w_cfg_bad;
                if (w_cfg_ok) w_state_nxt = S_WAIT;
            end
            S_WAIT: if (next) w_state_nxt = S_RUN;
            S_RUN: begin
                w_push = w_at_last;
                if (w_at_last) w_state_nxt = S_DONE;
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else r_state <= w_state_nxt;
    end

    // Frame length latch, sample index and the delayed config-error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx     <= '0;
            r_len     <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg_bad;
            if (w_cfg_ok) r_len <= w_len_dec;
            r_idx <= (r_state == S_RUN) ? r_idx + 1'b1 : '0;
        end
    end

    complex_result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_data    (in),
        .i_pop     (out_ready),
        .o_data    (out),
        .o_valid   (out_valid),
        .o_overflow(overflow)
    );

endmodule

// File: tb/tb_accum_result_collector.sv
// tb_accum_result_collector: scoreboard bench for the frame result collector
module tb_accum_result_collector;
    import accum_result_collector_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    complex_t   in;
    logic       next;
    logic       config_valid;
    logic [8:0] config_length;
    logic       busy;
    logic       cfg_err;
    complex_t   out;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    complex_t   q[$];

    accum_result_collector dut (
        .clk          (clk),
        .reset        (reset),
        .in           (in),
        .next         (next),
        .config_valid (config_valid),
        .config_length(config_length),
        .busy         (busy),
        .cfg_err      (cfg_err),
        .out          (out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic complex_t f(input int c);
        complex_t v;
        v.r = 32'h43480000 + 32'(c) * 32'h10;
        v.i = 32'h43480000 + 32'(c) * 32'h10;
        return v;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
        in = f(cyc);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step;
        step;
        reset = 1'b0;
        q.delete();
    endtask

    task automatic do_frame(input logic [8:0] lenc, output complex_t e);
        int len;
        len = (lenc == 0) ? 512 : int'(lenc);
        config_valid = 1'b1;
        config_length = lenc;
        step;
        config_valid = 1'b0;
        next = 1'b1;
        step;
        next = 1'b0;
        repeat (len - 1) step;
        e = f(cyc);
        step;
        step;
    endtask

    task automatic drain(input int n, input string tag);
        int got = 0;
        int guard = 0;
        out_ready = 1'b1;
        while (got < n && guard < 100) begin
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_unexpected: got %h want no result", tag, out);
                end else begin
                    if (out !== q[0]) begin
                        errors++;
                        $display("FAIL %s_data: got %h want %h", tag, out, q[0]);
                    end
                    void'(q.pop_front());
                end
                got++;
            end
            step;
            guard++;
        end
        out_ready = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s_count: got %0d results want %0d", tag, got, n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        next = 1'b0;
        config_valid = 1'b0;
        config_length = '0;
        out_ready = 1'b0;
        in = f(0);
        repeat (3) step;
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err: got %b want 0", cfg_err); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        if (out !== 64'h0) begin errors++; $display("FAIL rst_out: got %h want 0", out); end
        reset = 1'b0;
        step;
    endtask

    task automatic test_basic;
        config_valid = 1'b1;
        config_length = 9'd3;
        step;
        config_valid = 1'b1;
        config_length = 9'd2;
        step;
        config_valid = 1'b0;
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_wait_busy: got %b want 1", busy); end
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL basic_busy_cfg_ignored: got %b want 0", cfg_err); end
        cyc = 9;
        step;
        next = 1'b1;
        step;
        next = 1'b0;
        step;
        step;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_c13: got %b want 0", out_valid); end
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_c13: got %b want 1", busy); end
        q.push_back(f(13));
        step;
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_c14: got %b want 1", out_valid); end
        if (out !== f(13)) begin errors++; $display("FAIL basic_out_c14: got %h want %h", out, f(13)); end
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_c14: got %b want 1", busy); end
        step;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_c15: got %b want 0", busy); end
        drain(1, "basic");
    endtask

    task automatic test_len512;
        int t;
        config_valid = 1'b1;
        config_length = 9'd0;
        step;
        config_valid = 1'b0;
        next = 1'b1;
        t = cyc;
        step;
        next = 1'b0;
        repeat (510) step;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL l512_early_t511: got %b want 0", out_valid); end
        step;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL l512_early_t512: got %b want 0", out_valid); end
        q.push_back(f(t + 512));
        step;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL l512_valid: got %b want 1", out_valid); end
        if (out !== f(t + 512)) begin errors++; $display("FAIL l512_out: got %h want %h", out, f(t + 512)); end
        step;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL l512_idle: got %b want 0", busy); end
        drain(1, "l512");
    endtask

    task automatic test_cfg_err;
        for (int k = 1; k <= 2; k++) begin
            config_valid = 1'b1;
            config_length = 9'(k);
            step;
            config_valid = 1'b0;
            checks += 2;
            if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfgerr_pulse_len%0d: got %b want 1", k, cfg_err); end
            if (busy !== 1'b0) begin errors++; $display("FAIL cfgerr_busy_len%0d: got %b want 0", k, busy); end
            step;
            checks++;
            if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfgerr_width_len%0d: got %b want 0", k, cfg_err); end
        end
        next = 1'b1;
        step;
        next = 1'b0;
        repeat (6) step;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL cfgerr_no_capture: got %b want 0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL cfgerr_stay_idle: got %b want 0", busy); end
    endtask

    task automatic test_overflow;
        complex_t e;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            do_frame(9'd4, e);
            if (k < 4) q.push_back(e);
            if (k == 3) begin
                checks++;
                if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        drain(4, "ovf");
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", out_valid); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        do_reset;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset_clear: got %b want 0", overflow); end
    endtask

    task automatic test_full_pushpop;
        complex_t e;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            do_frame(9'd3, e);
            q.push_back(e);
        end
        config_valid = 1'b1;
        config_length = 9'd3;
        step;
        config_valid = 1'b0;
        next = 1'b1;
        step;
        next = 1'b0;
        step;
        step;
        out_ready = 1'b1;
        checks++;
        if (out !== q[0]) begin errors++; $display("FAIL full_head: got %h want %h", out, q[0]); end
        void'(q.pop_front());
        e = f(cyc);
        step;
        out_ready = 1'b0;
        q.push_back(e);
        checks += 2;
        if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_overflow: got %b want 0", overflow); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", out_valid); end
        step;
        drain(4, "full");
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midrun;
        complex_t e;
        do_reset;
        config_valid = 1'b1;
        config_length = 9'd8;
        step;
        config_valid = 1'b0;
        next = 1'b1;
        step;
        next = 1'b0;
        repeat (5) step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        repeat (12) step;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_capture: got %b want 0", out_valid); end
        do_frame(9'd8, e);
        q.push_back(e);
        drain(1, "midrst");
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_single: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_len512;
        test_cfg_err;
        test_overflow;
        test_full_pushpop;
        test_reset_midrun;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
